// File: rtl/operand_fetch.sv
// Operand fetch stage: reads the register bank, forwards writeback data,
// tracks in-flight destinations and holds one instruction for execute.
module operand_fetch #(
    parameter int BANK_WIDTH     = 5,
    parameter int REGISTER_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    // decode side
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BANK_WIDTH-1:0]     in_rs1,
    input  logic [BANK_WIDTH-1:0]     in_rs2,
    input  logic [BANK_WIDTH-1:0]     in_rd,
    input  logic                      in_use_rs1,
    input  logic                      in_use_rs2,
    input  logic                      in_rd_we,
    input  logic [31:0]               in_pc,
    // execute side
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [REGISTER_WIDTH-1:0] out_rs1_val,
    output logic [REGISTER_WIDTH-1:0] out_rs2_val,
    output logic [BANK_WIDTH-1:0]     out_rd,
    output logic                      out_rd_we,
    output logic [31:0]               out_pc,
    // writeback side
    input  logic                      wb_valid,
    input  logic [BANK_WIDTH-1:0]     wb_rd,
    input  logic [REGISTER_WIDTH-1:0] wb_data,
    // register bank
    output logic [BANK_WIDTH-1:0]     rs1_sel,
    output logic [BANK_WIDTH-1:0]     rs2_sel,
    output logic [BANK_WIDTH-1:0]     rd_sel,
    output logic                      reg_w,
    output logic [REGISTER_WIDTH-1:0] rd_data,
    input  logic [REGISTER_WIDTH-1:0] rs1_data,
    input  logic [REGISTER_WIDTH-1:0] rs2_data,
    input  logic                      bank_ready,
    output logic [1:0]                state
);

    localparam int NREG = 2 ** BANK_WIDTH;

    typedef enum logic [1:0] {
        DRAIN = 2'd0,
        INIT  = 2'd1,
        RUN   = 2'd2
    } state_e;

    state_e                    state_q;
    logic [NREG-1:0]           pend_q, pend_d;
    logic [NREG-1:0]           clr, set, eff_pend;
    logic                      hazard, accept, leave_run;
    logic                      out_valid_q;
    logic [REGISTER_WIDTH-1:0] rs1_val_q, rs2_val_q;
    logic [REGISTER_WIDTH-1:0] op1, op2;
    logic [BANK_WIDTH-1:0]     rd_q;
    logic                      rd_we_q;
    logic [31:0]               pc_q;

    function automatic logic [REGISTER_WIDTH-1:0] pick(
        input logic [BANK_WIDTH-1:0]     sel,
        input logic                      use_it,
        input logic [REGISTER_WIDTH-1:0] bank
    );
        if (sel == '0 || !use_it) return '0;
        if (wb_valid && wb_rd == sel) return wb_data;
        return bank;
    endfunction

    assign rs1_sel   = in_rs1;
    assign rs2_sel   = in_rs2;
    assign rd_sel    = wb_rd;
    assign rd_data   = wb_data;
    assign reg_w     = wb_valid && wb_rd != '0 && bank_ready;
    assign state     = state_q;
    assign out_valid = out_valid_q;
    assign out_rs1_val = rs1_val_q;
    assign out_rs2_val = rs2_val_q;
    assign out_rd    = rd_q;
    assign out_rd_we = rd_we_q;
    assign out_pc    = pc_q;

    assign op1 = pick(in_rs1, in_use_rs1, rs1_data);
    assign op2 = pick(in_rs2, in_use_rs2, rs2_data);

    assign in_ready = !rst && state_q == RUN && !hazard &&
                      (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign leave_run = state_q == RUN && !bank_ready;

    // Scoreboard view with same-cycle writeback already retired
    always_comb begin
        clr = '0;
        set = '0;
        if (wb_valid) clr[wb_rd] = 1'b1;
        if (accept && in_rd_we && in_rd != '0) set[in_rd] = 1'b1;
        eff_pend = pend_q & ~clr;
        hazard = (in_use_rs1 && in_rs1 != '0 && eff_pend[in_rs1]) ||
                 (in_use_rs2 && in_rs2 != '0 && eff_pend[in_rs2]) ||
                 (in_rd_we && in_rd != '0 && eff_pend[in_rd]);
        pend_d = eff_pend | set;
        pend_d[0] = 1'b0;
    end

    // Bank bring-up sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DRAIN;
        end else begin
            case (state_q)
                DRAIN:   if (!bank_ready) state_q <= INIT;
                INIT:    if (bank_ready) state_q <= RUN;
                RUN:     if (!bank_ready) state_q <= INIT;
                default: state_q <= DRAIN;
            endcase
        end
    end

    // Scoreboard and execute-side holding register
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q      <= '0;
            out_valid_q <= 1'b0;
            rs1_val_q   <= '0;
            rs2_val_q   <= '0;
            rd_q        <= '0;
            rd_we_q     <= 1'b0;
            pc_q        <= '0;
        end else begin
            if (leave_run) begin
                pend_q      <= '0;
                out_valid_q <= 1'b0;
            end else begin
                pend_q <= pend_d;
                if (accept) out_valid_q <= 1'b1;
                else if (out_ready) out_valid_q <= 1'b0;
            end
            if (accept) begin
                rs1_val_q <= op1;
                rs2_val_q <= op2;
                rd_q      <= in_rd;
                rd_we_q   <= in_rd_we;
                pc_q      <= in_pc;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios plus random traffic
// against a behavioural model of scoreboard, bank and output slot.
module tb_operand_fetch;

    localparam int BW = 5;
    localparam int RW = 32;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    logic [BW-1:0] in_rs1, in_rs2, in_rd;
    logic          in_use_rs1, in_use_rs2, in_rd_we;
    logic [31:0]   in_pc;
    logic          out_valid, out_ready;
    logic [RW-1:0] out_rs1_val, out_rs2_val;
    logic [BW-1:0] out_rd;
    logic          out_rd_we;
    logic [31:0]   out_pc;
    logic          wb_valid;
    logic [BW-1:0] wb_rd;
    logic [RW-1:0] wb_data;
    logic [BW-1:0] rs1_sel, rs2_sel, rd_sel;
    logic          reg_w;
    logic [RW-1:0] rd_data, rs1_data, rs2_data;
    logic          bank_ready;
    logic [1:0]    state;

    always #5 clk = ~clk;

    operand_fetch #(.BANK_WIDTH(BW), .REGISTER_WIDTH(RW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
        .in_rd_we(in_rd_we), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_rd(out_rd), .out_rd_we(out_rd_we), .out_pc(out_pc),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .rs1_sel(rs1_sel), .rs2_sel(rs2_sel), .rd_sel(rd_sel),
        .reg_w(reg_w), .rd_data(rd_data),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .bank_ready(bank_ready), .state(state)
    );

    // register bank model
    logic [RW-1:0] regs [NR];
    assign rs1_data = regs[rs1_sel];
    assign rs2_data = regs[rs2_sel];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // reference model state
    int          m_state;
    bit          m_pend [NR];
    bit          m_ov;
    logic [31:0] m_r1, m_r2, m_pc;
    int          m_rd;
    bit          m_rdwe;

    function automatic bit busy(input int r);
        if (r == 0) return 1'b0;
        if (wb_valid && int'(wb_rd) == r) return 1'b0;
        return m_pend[r];
    endfunction

    function automatic bit m_hazard();
        return (in_use_rs1 && busy(int'(in_rs1))) ||
               (in_use_rs2 && busy(int'(in_rs2))) ||
               (in_rd_we && busy(int'(in_rd)));
    endfunction

    function automatic logic [31:0] opnd(input int sel, input bit u,
                                         input logic [31:0] bank);
        if (sel == 0 || !u) return 32'h0;
        if (wb_valid && int'(wb_rd) == sel) return wb_data;
        return bank;
    endfunction

    // one clock: check comb outputs, advance model, check registers
    task automatic cyc();
        bit rdy, acc, leave, do_w;
        int w_idx;
        logic [31:0] w_dat;
        #1;
        rdy = !rst && m_state == 2 && !m_hazard() && (!m_ov || out_ready);
        do_w = wb_valid && wb_rd != 0 && bank_ready;
        w_idx = int'(wb_rd);
        w_dat = wb_data;
        chk("in_ready", in_ready, rdy);
        chk("reg_w", reg_w, do_w);
        chk("rs1_sel", rs1_sel, in_rs1);
        chk("rs2_sel", rs2_sel, in_rs2);
        chk("rd_sel", rd_sel, wb_rd);
        chk("rd_data", rd_data, wb_data);
        acc = in_valid && rdy;
        if (rst) begin
            m_state = 0;
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_ov = 0; m_r1 = 0; m_r2 = 0; m_pc = 0; m_rd = 0; m_rdwe = 0;
        end else begin
            leave = m_state == 2 && !bank_ready;
            if (acc) begin
                m_r1 = opnd(int'(in_rs1), in_use_rs1, regs[in_rs1]);
                m_r2 = opnd(int'(in_rs2), in_use_rs2, regs[in_rs2]);
                m_rd = int'(in_rd); m_rdwe = in_rd_we; m_pc = in_pc;
                m_ov = 1;
            end else if (out_ready) begin
                m_ov = 0;
            end
            if (wb_valid) m_pend[wb_rd] = 1'b0;
            if (acc && in_rd_we && in_rd != 0) m_pend[in_rd] = 1'b1;
            if (leave) begin
                foreach (m_pend[i]) m_pend[i] = 1'b0;
                m_ov = 0;
            end
            case (m_state)
                0: if (!bank_ready) m_state = 1;
                1: if (bank_ready) m_state = 2;
                default: if (!bank_ready) m_state = 1;
            endcase
        end
        @(posedge clk);
        @(negedge clk);
        if (do_w) regs[w_idx] = w_dat;
        chk("state", state, m_state);
        chk("out_valid", out_valid, m_ov);
        chk("out_rs1_val", out_rs1_val, m_r1);
        chk("out_rs2_val", out_rs2_val, m_r2);
        chk("out_rd", out_rd, m_rd);
        chk("out_rd_we", out_rd_we, m_rdwe);
        chk("out_pc", out_pc, m_pc);
    endtask

    task automatic idle();
        in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
        in_use_rs1 = 0; in_use_rs2 = 0; in_rd_we = 0; in_pc = 0;
        wb_valid = 0; wb_rd = 0; wb_data = 0; out_ready = 1;
    endtask

    task automatic to_run();
        bank_ready = 0; cyc();
        bank_ready = 1; cyc();
        chk("to_run", state, 2'd2);
    endtask

    task automatic issue(input int rs1, input bit u1, input int rd,
                         input bit we, input logic [31:0] pc);
        in_valid = 1; in_rs1 = BW'(rs1); in_use_rs1 = u1;
        in_rs2 = 0; in_use_rs2 = 0;
        in_rd = BW'(rd); in_rd_we = we; in_pc = pc;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) regs[i] = 32'h1000_0000 + i;
        m_state = 0; m_ov = 0; m_r1 = 0; m_r2 = 0; m_pc = 0;
        m_rd = 0; m_rdwe = 0;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        idle();
        rst = 1; bank_ready = 0;

        // power-up sequence
        cyc();
        chk("pwr_drain", state, 2'd0);
        rst = 0;
        for (int i = 0; i < 33; i++) cyc();
        chk("pwr_init", state, 2'd1);
        bank_ready = 1;
        cyc();
        chk("pwr_run", state, 2'd2);

        // RAW stall and forwarding
        issue(0, 0, 5, 1, 32'h100); cyc();
        issue(5, 1, 6, 0, 32'h104);
        #1 chk("raw_stall", in_ready, 1'b0);
        cyc(); cyc();
        wb_valid = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
        #1 chk("raw_release", in_ready, 1'b1);
        cyc();
        chk("raw_fwd", out_rs1_val, 32'hDEADBEEF);
        idle(); cyc();

        // x0 handling
        in_valid = 1; in_use_rs1 = 1; in_use_rs2 = 1; in_rd_we = 1;
        in_pc = 32'h200;
        wb_valid = 1; wb_rd = 0; wb_data = 32'h1234;
        #1 chk("x0_regw", reg_w, 1'b0);
        cyc();
        chk("x0_op1", out_rs1_val, 32'h0);
        chk("x0_op2", out_rs2_val, 32'h0);
        idle();
        issue(0, 1, 0, 0, 32'h204);
        #1 chk("x0_nostall", in_ready, 1'b1);
        cyc(); idle(); cyc();

        // backpressure
        issue(2, 1, 0, 0, 32'hAAA); out_ready = 0; cyc();
        issue(3, 1, 0, 0, 32'hBBB);
        for (int i = 0; i < 10; i++) begin
            #1 chk("bp_stall", in_ready, 1'b0);
            cyc();
            chk("bp_hold", out_pc, 32'hAAA);
        end
        out_ready = 1;
        #1 chk("bp_go", in_ready, 1'b1);
        cyc();
        chk("bp_next", out_pc, 32'hBBB);
        idle(); cyc();

        // simultaneous writeback and re-issue of same rd
        issue(0, 0, 7, 1, 32'h300); cyc();
        issue(0, 0, 7, 1, 32'h304);
        wb_valid = 1; wb_rd = 7; wb_data = 32'h77;
        #1 chk("waw_accept", in_ready, 1'b1);
        cyc();
        idle();
        issue(7, 1, 0, 0, 32'h308);
        #1 chk("waw_pend7", in_ready, 1'b0);
        cyc(); idle(); cyc();

        // reset mid-stall
        issue(0, 0, 3, 1, 32'h400); out_ready = 0; cyc();
        issue(1, 1, 0, 0, 32'h404);
        rst = 1; cyc();
        chk("rst_state", state, 2'd0);
        chk("rst_ov", out_valid, 1'b0);
        chk("rst_pc", out_pc, 32'h0);
        rst = 0; idle();
        to_run();
        issue(3, 1, 0, 0, 32'h408);
        #1 chk("rst_nopend", in_ready, 1'b1);
        cyc(); idle(); cyc();

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            bank_ready = ($urandom_range(0, 29) != 0);
            in_valid = ($urandom_range(0, 9) < 7);
            in_rs1 = BW'($urandom_range(0, 7));
            in_rs2 = BW'($urandom_range(0, 7));
            in_rd = BW'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) in_rd = BW'($urandom_range(0, NR - 1));
            in_use_rs1 = 1'($urandom_range(0, 1));
            in_use_rs2 = 1'($urandom_range(0, 1));
            in_rd_we = 1'($urandom_range(0, 1));
            in_pc = $urandom;
            out_ready = ($urandom_range(0, 9) < 7);
            wb_valid = ($urandom_range(0, 9) < 4);
            wb_rd = BW'($urandom_range(0, 7));
            wb_data = $urandom;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter BANK_WIDTH, default 5, register-select width (2**BANK_WIDTH registers).
REQ-002 SHALL have parameter REGISTER_WIDTH, default 32, operand/data width.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk input 1, rst input 1.
REQ-004 SHALL have decode-side ports:
- in_valid input 1; in_ready output 1
- in_rs1, in_rs2, in_rd input BANK_WIDTH
- in_use_rs1, in_use_rs2, in_rd_we input 1
- in_pc input 32, passthrough tag
REQ-005 SHALL have execute-side ports:
- out_valid output 1; out_ready input 1
- out_rs1_val, out_rs2_val output REGISTER_WIDTH
- out_rd output BANK_WIDTH; out_rd_we output 1; out_pc output 32
REQ-006 SHALL have writeback-side ports: wb_valid input 1; wb_rd input BANK_WIDTH; wb_data input REGISTER_WIDTH.
REQ-007 SHALL have register-bank ports:
- rs1_sel, rs2_sel, rd_sel output BANK_WIDTH; reg_w output 1
- rd_data output REGISTER_WIDTH
- rs1_data, rs2_data input REGISTER_WIDTH; bank_ready input 1
- state output 2, debug

Function
REQ-008 SHALL implement FSM DRAIN(0) -> INIT(1) -> RUN(2): DRAIN exits when bank_ready==0; INIT exits when bank_ready==1; RUN returns to INIT when bank_ready==0.
REQ-009 SHALL drive rs1_sel=in_rs1, rs2_sel=in_rs2, rd_sel=wb_rd, rd_data=wb_data combinationally.
REQ-010 SHALL drive reg_w = wb_valid && wb_rd!=0 && bank_ready; writes while bank not ready are dropped.
REQ-011 SHALL keep scoreboard pend[2**BANK_WIDTH-1:0], one bit per register; pend[0] always 0.
REQ-012 SHALL compute eff_pend = pend with bit wb_rd cleared when wb_valid.
REQ-013 SHALL flag hazard = (in_use_rs1 && in_rs1!=0 && eff_pend[in_rs1]) || (same for rs2) || (in_rd_we && in_rd!=0 && eff_pend[in_rd]).
REQ-014 SHALL drive in_ready = (state==RUN) && !hazard && (!out_valid || out_ready), combinational.
REQ-015 SHALL select each operand: zero if select==0 or use bit low; else wb_data if wb_valid && wb_rd==select; else bank data.
REQ-016 SHALL, on in_valid && in_ready, load out_* registers next edge (latency 1), set out_valid=1, set pend[in_rd] if in_rd_we && in_rd!=0.
REQ-017 SHALL update pend as next = (pend & ~clr) | set; on same register set wins.
REQ-018 SHALL clear out_valid on out_valid && out_ready && no new accept; out_* SHALL stay stable while out_valid && !out_ready.
REQ-019 SHALL clear pend[wb_rd] on wb_valid even if not set; no error raised.
REQ-020 SHALL, on RUN->INIT, clear all pend and out_valid; wb traffic then only clears pend.

Reset
REQ-021 SHALL, on rst at posedge, set state=DRAIN, pend=0, out_valid=0, out_rs1_val=out_rs2_val=0, out_rd=0, out_rd_we=0, out_pc=0.
REQ-022 SHALL hold in_ready=0 during rst and until RUN; rst overrides all same-cycle accept and wb scoreboard updates.
REQ-023 SHALL tolerate rst mid-stall: held instruction is discarded, no pend survives.

Verification
REQ-024 Power-up: rst 1 cycle, bank_ready 0 for 33 cycles then 1 -> state DRAIN, INIT, RUN; in_ready 1 only in RUN.
REQ-025 RAW stall: issue rd=5 rd_we=1; next issue rs1=5 -> in_ready=0 until wb_valid wb_rd=5 wb_data=0xDEADBEEF; that cycle accept, out_rs1_val=0xDEADBEEF next cycle.
REQ-026 x0: issue rs1=0 rs2=0 rd=0 rd_we=1, then wb_rd=0 wb_data=0x1234 -> operands 0, reg_w=0, pend[0]=0, no stall.
REQ-027 Backpressure: out_ready=0 with out_valid=1 -> in_ready=0, out_* unchanged for 10 cycles; out_ready=1 -> next instruction loads next edge.
REQ-028 WAW/simultaneous: pend[7]=1, wb_rd=7 plus issue rd=7 rd_we=1 same cycle -> accepted, pend[7]=1 afterward.
REQ-029 Reset mid-operation: pend[3]=1, out_valid=1, rst -> next edge all outputs zero, pend=0, state=DRAIN.
